// File: rtl/m65c02_msu_seq_if.sv
// Request, result and shift-unit signal bundle for the M65C02A multi-cycle shift/rotate sequencer.
// slave: the sequencer; master: the requester together with the single-bit shift unit.
interface m65c02_msu_seq_if;
    logic       Start;
    logic       Op;
    logic       Rot;
    logic [3:0] Cnt;
    logic [7:0] A;
    logic       Ci;
    logic       SU_En;
    logic       SU_Op;
    logic [7:0] SU_D;
    logic       SU_Ci;
    logic [8:0] SU_Out;
    logic       SU_OV;
    logic       Busy;
    logic       Done;
    logic [7:0] Q;
    logic       C;
    logic       V;
    logic       N;
    logic       Z;

    modport slave (
        input  Start, Op, Rot, Cnt, A, Ci, SU_Out, SU_OV,
        output SU_En, SU_Op, SU_D, SU_Ci, Busy, Done, Q, C, V, N, Z
    );

    modport master (
        output Start, Op, Rot, Cnt, A, Ci, SU_Out, SU_OV,
        input  SU_En, SU_Op, SU_D, SU_Ci, Busy, Done, Q, C, V, N, Z
    );
endinterface

// File: rtl/m65c02_msu_seq.sv
// Multi-cycle shift/rotate sequencer driving the single-bit SU once per clock.
// Optional count reduction: define M65C02_MSU_CNT_REDUCE_EN.
module m65c02_msu_seq (
    input  logic                 Clk,
    input  logic                 nRst,
    m65c02_msu_seq_if.slave      bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] d_q, d_d;
    logic       cr_q, cr_d;
    logic       vr_q, vr_d;
    logic       op_q, op_d;
    logic       rot_q, rot_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] q_q, q_d;
    logic       c_q, c_d;
    logic       v_q, v_d;
    logic [3:0] ne_s;
    logic       vr_nxt_s;

    // Effective iteration count for the incoming request
    always_comb begin
`ifdef M65C02_MSU_CNT_REDUCE_EN
        // A 9-bit ring repeats every 9 rotates; 9+ logical shifts already clear D and C
        if (bus.Rot) begin
            ne_s = (bus.Cnt >= 4'd9) ? (bus.Cnt - 4'd9) : bus.Cnt;
        end else begin
            ne_s = (bus.Cnt > 4'd9) ? 4'd9 : bus.Cnt;
        end
`else
        ne_s = bus.Cnt;
`endif
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            d_q     <= 8'h00;
            cr_q    <= 1'b0;
            vr_q    <= 1'b0;
            op_q    <= 1'b0;
            rot_q   <= 1'b0;
            cnt_q   <= 4'd0;
            q_q     <= 8'h00;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            cr_q    <= cr_d;
            vr_q    <= vr_d;
            op_q    <= op_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        cr_d     = cr_q;
        vr_d     = vr_q;
        op_d     = op_q;
        rot_d    = rot_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        c_d      = c_q;
        v_d      = v_q;
        vr_nxt_s = vr_q | (bus.SU_OV & ~op_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    d_d   = bus.A;
                    cr_d  = bus.Ci;
                    vr_d  = 1'b0;
                    op_d  = bus.Op;
                    rot_d = bus.Rot;
                    cnt_d = ne_s;
                    if (ne_s == 4'd0) begin
                        // Nothing to shift: the captured operand is the result
                        state_d = ST_DONE;
                        q_d     = bus.A;
                        c_d     = bus.Ci;
                        v_d     = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {cr_d, d_d} = bus.SU_Out;
                vr_d        = vr_nxt_s;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    q_d     = bus.SU_Out[7:0];
                    c_d     = bus.SU_Out[8];
                    v_d     = vr_nxt_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.SU_En = (state_q == ST_SHIFT);
    assign bus.Busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.Done  = (state_q == ST_DONE);
    assign bus.SU_Op = op_q;
    assign bus.SU_D  = d_q;
    assign bus.SU_Ci = rot_q & cr_q;
    assign bus.Q     = q_q;
    assign bus.C     = c_q;
    assign bus.V     = v_q;
    assign bus.N     = q_q[7];
    assign bus.Z     = (q_q == 8'h00);
endmodule
